// File: rtl/rom_arbiter.sv
// Three-way round-robin arbiter that shares one SDRAM read port between the
// 68k program ROM, the Z80 program ROM and the sprite ROM.
module rom_arbiter #(
  parameter logic [23:0] Z80_BASE = 24'h040000,
  parameter logic [23:0] GFX_BASE = 24'h050000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_req,
  input  logic [17:0] m68k_addr,
  output logic        m68k_ack,
  output logic [15:0] m68k_dout,
  input  logic        z80_req,
  input  logic [15:0] z80_addr,
  output logic        z80_ack,
  output logic [7:0]  z80_dout,
  input  logic        gfx_req,
  input  logic [19:0] gfx_addr,
  output logic        gfx_ack,
  output logic [15:0] gfx_dout,
  output logic        sdram_req,
  output logic [23:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic [1:0] {SRC_M68K, SRC_Z80, SRC_GFX} src_t;

  state_t      state_q, state_d;
  src_t        grant_q, grant_d;
  src_t        last_q, last_d;
  logic        abort_q, abort_d;
  logic        z80_lsb_q, z80_lsb_d;
  logic        sdram_req_q, sdram_req_d;
  logic [23:0] sdram_addr_q, sdram_addr_d;
  logic [2:0]  ack_q, ack_d;
  logic [15:0] m68k_dout_q, m68k_dout_d;
  logic [7:0]  z80_dout_q, z80_dout_d;
  logic [15:0] gfx_dout_q, gfx_dout_d;

  logic [2:0]  req_vec;
  logic [23:0] addr_m68k, addr_z80, addr_gfx;
  logic        granted_req;
  src_t        winner;

  assign req_vec = {gfx_req, z80_req, m68k_req};

  // Byte addresses are word-aligned by masking bit 0 of both offset and sum.
  assign addr_m68k = {6'b0, m68k_addr} & 24'hFFFFFE;
  assign addr_z80  = (Z80_BASE + ({8'b0, z80_addr} & 24'hFFFFFE)) & 24'hFFFFFE;
  assign addr_gfx  = (GFX_BASE + ({4'b0, gfx_addr} & 24'hFFFFFE)) & 24'hFFFFFE;

  // Search starts at the requester after the last grant; falls back to last.
  function automatic src_t pick(input src_t last, input logic [2:0] req);
    src_t r;
    case (last)
      SRC_M68K: r = req[1] ? SRC_Z80  : (req[2] ? SRC_GFX  : SRC_M68K);
      SRC_Z80:  r = req[2] ? SRC_GFX  : (req[0] ? SRC_M68K : SRC_Z80);
      default:  r = req[0] ? SRC_M68K : (req[1] ? SRC_Z80  : SRC_GFX);
    endcase
    return r;
  endfunction

  assign winner = pick(last_q, req_vec);

  always_comb begin
    case (grant_q)
      SRC_M68K: granted_req = m68k_req;
      SRC_Z80:  granted_req = z80_req;
      default:  granted_req = gfx_req;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    abort_d      = abort_q;
    z80_lsb_d    = z80_lsb_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    ack_d        = 3'b000;
    m68k_dout_d  = m68k_dout_q;
    z80_dout_d   = z80_dout_q;
    gfx_dout_d   = gfx_dout_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          grant_d     = winner;
          last_d      = winner;
          abort_d     = 1'b0;
          z80_lsb_d   = z80_addr[0];
          sdram_req_d = 1'b1;
          case (winner)
            SRC_M68K: sdram_addr_d = addr_m68k;
            SRC_Z80:  sdram_addr_d = addr_z80;
            default:  sdram_addr_d = addr_gfx;
          endcase
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A requester that drops its req mid-transfer gets neither data nor ack.
        if (!granted_req) abort_d = 1'b1;
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = ST_DONE;
          if (!abort_q && granted_req) begin
            case (grant_q)
              SRC_M68K: begin
                m68k_dout_d = sdram_data;
                ack_d[0]    = 1'b1;
              end
              SRC_Z80: begin
                z80_dout_d = z80_lsb_q ? sdram_data[15:8] : sdram_data[7:0];
                ack_d[1]   = 1'b1;
              end
              default: begin
                gfx_dout_d = sdram_data;
                ack_d[2]   = 1'b1;
              end
            endcase
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the captured data, is cleared by reset so outputs start at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= SRC_M68K;
      last_q       <= SRC_GFX;
      abort_q      <= 1'b0;
      z80_lsb_q    <= 1'b0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= 24'h0;
      ack_q        <= 3'b000;
      m68k_dout_q  <= 16'h0;
      z80_dout_q   <= 8'h0;
      gfx_dout_q   <= 16'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      abort_q      <= abort_d;
      z80_lsb_q    <= z80_lsb_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      ack_q        <= ack_d;
      m68k_dout_q  <= m68k_dout_d;
      z80_dout_q   <= z80_dout_d;
      gfx_dout_q   <= gfx_dout_d;
    end
  end

  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign m68k_ack   = ack_q[0];
  assign z80_ack    = ack_q[1];
  assign gfx_ack    = ack_q[2];
  assign m68k_dout  = m68k_dout_q;
  assign z80_dout   = z80_dout_q;
  assign gfx_dout   = gfx_dout_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a table of single-requester fetches plus
// hand-written round-robin, abort, stray-ack and reset-in-BUSY sequences.
module tb_rom_arbiter;

  localparam int SRC_M = 0;
  localparam int SRC_Z = 1;
  localparam int SRC_G = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        m68k_req, z80_req, gfx_req;
  logic [17:0] m68k_addr;
  logic [15:0] z80_addr;
  logic [19:0] gfx_addr;
  logic        m68k_ack, z80_ack, gfx_ack;
  logic [15:0] m68k_dout, gfx_dout;
  logic [7:0]  z80_dout;
  logic        sdram_req, sdram_ack;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] mdl_dout [3];

  always #5 clk = ~clk;

  rom_arbiter #(.Z80_BASE(24'h040000), .GFX_BASE(24'hFF0000)) dut (
    .clk(clk), .reset(reset),
    .m68k_req(m68k_req), .m68k_addr(m68k_addr), .m68k_ack(m68k_ack), .m68k_dout(m68k_dout),
    .z80_req(z80_req), .z80_addr(z80_addr), .z80_ack(z80_ack), .z80_dout(z80_dout),
    .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack), .gfx_dout(gfx_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_data(sdram_data)
  );

  typedef struct {
    int          src;
    logic [19:0] addr;
    logic [15:0] data;
    int          delay;
    logic [23:0] exp_addr;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int src, input logic val, input logic [19:0] addr);
    case (src)
      SRC_M: begin m68k_req = val; m68k_addr = addr[17:0]; end
      SRC_Z: begin z80_req = val; z80_addr = addr[15:0]; end
      default: begin gfx_req = val; gfx_addr = addr; end
    endcase
  endtask

  task automatic check_douts(input string name);
    check({name, " m68k_dout"}, {16'h0, m68k_dout}, {16'h0, mdl_dout[0]});
    check({name, " z80_dout"}, {24'h0, z80_dout}, {24'h0, mdl_dout[1][7:0]});
    check({name, " gfx_dout"}, {16'h0, gfx_dout}, {16'h0, mdl_dout[2]});
  endtask

  // Bounded wait for sdram_req; returns the number of negedges waited.
  task automatic wait_sreq(output int cyc);
    cyc = 0;
    while (!sdram_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int cyc;
    set_req(v.src, 1'b1, v.addr);
    wait_sreq(cyc);
    check({name, " latency"}, cyc, 1);
    check({name, " sdram_addr"}, {8'h0, sdram_addr}, {8'h0, v.exp_addr});
    for (int i = 1; i < v.delay; i++) begin
      @(negedge clk);
      check({name, " hold"}, {7'h0, sdram_req, sdram_addr}, {7'h0, 1'b1, v.exp_addr});
    end
    sdram_data = v.data;
    sdram_ack  = 1'b1;
    @(negedge clk);
    sdram_ack  = 1'b0;
    mdl_dout[v.src] = v.exp_dout;
    check({name, " acks"}, {29'h0, gfx_ack, z80_ack, m68k_ack}, 32'(3'b001 << v.src));
    check({name, " sdram_req low"}, {31'h0, sdram_req}, 32'h0);
    check_douts(name);
    set_req(v.src, 1'b0, v.addr);
    @(negedge clk);
    check({name, " ack pulse ends"}, {29'h0, gfx_ack, z80_ack, m68k_ack}, 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " sdram"}, {7'h0, sdram_req, sdram_addr}, 32'h0);
    check({name, " acks"}, {29'h0, gfx_ack, z80_ack, m68k_ack}, 32'h0);
    check({name, " douts"}, {m68k_dout, z80_dout, 8'h0} | {16'h0, gfx_dout}, 32'h0);
  endtask

  initial begin
    int cyc;
    int order [6];
    logic [23:0] rr_addr [3];
    logic [19:0] rr_req_addr [3];
    vec_t v;

    vecs[0] = '{SRC_M, 20'h01235, 16'hBEEF, 3, 24'h001234, 16'hBEEF};
    vecs[1] = '{SRC_Z, 20'h01001, 16'hA55A, 1, 24'h041000, 16'h00A5};
    vecs[2] = '{SRC_Z, 20'h01000, 16'hA55A, 2, 24'h041000, 16'h005A};
    vecs[3] = '{SRC_G, 20'hFFFFE, 16'h1234, 1, 24'h0EFFFE, 16'h1234};
    vecs[4] = '{SRC_M, 20'h3FFFF, 16'hCAFE, 1, 24'h03FFFE, 16'hCAFE};
    vecs[5] = '{SRC_G, 20'h00001, 16'h5AA5, 4, 24'hFF0000, 16'h5AA5};
    vecs[6] = '{SRC_Z, 20'h0FFFF, 16'h1357, 1, 24'h04FFFE, 16'h0013};

    order = '{SRC_M, SRC_Z, SRC_G, SRC_M, SRC_Z, SRC_G};
    rr_req_addr = '{20'h00100, 20'h00200, 20'h00300};
    rr_addr     = '{24'h000100, 24'h040200, 24'hFF0300};
    for (int i = 0; i < 3; i++) mdl_dout[i] = 16'h0;

    reset = 1'b1;
    m68k_req = 0; z80_req = 0; gfx_req = 0;
    m68k_addr = 0; z80_addr = 0; gfx_addr = 0;
    sdram_ack = 0; sdram_data = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Stray sdram_ack while idle must not disturb anything.
    sdram_data = 16'hDEAD;
    sdram_ack  = 1'b1;
    @(negedge clk);
    sdram_ack  = 1'b0;
    check("stray ack", {28'h0, sdram_req, gfx_ack, z80_ack, m68k_ack}, 32'h0);
    check_douts("stray ack");

    // Abort: m68k drops req during BUSY; data must not land and no ack.
    set_req(SRC_M, 1'b1, 20'h00010);
    wait_sreq(cyc);
    check("abort grant", {31'h0, sdram_req}, 32'h1);
    m68k_req = 1'b0;
    @(negedge clk);
    check("abort still busy", {31'h0, sdram_req}, 32'h1);
    sdram_data = 16'h7777;
    sdram_ack  = 1'b1;
    @(negedge clk);
    sdram_ack  = 1'b0;
    check("abort acks", {28'h0, sdram_req, gfx_ack, z80_ack, m68k_ack}, 32'h0);
    check_douts("abort");
    @(negedge clk);
    v = '{SRC_Z, 20'h00002, 16'h6789, 1, 24'h040002, 16'h0089};
    run_txn(v, "after abort");

    // Reset during BUSY, then a late sdram_ack.
    set_req(SRC_M, 1'b1, 20'h00020);
    wait_sreq(cyc);
    check("rst grant", {31'h0, sdram_req}, 32'h1);
    reset = 1'b1;
    m68k_req = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) mdl_dout[i] = 16'h0;
    check_all_zero("rst in busy");
    @(negedge clk);
    reset = 1'b0;
    sdram_data = 16'h4444;
    sdram_ack  = 1'b1;
    @(negedge clk);
    sdram_ack  = 1'b0;
    check_all_zero("late ack");
    @(negedge clk);
    check_all_zero("late ack after");
    v = '{SRC_M, 20'h00020, 16'h9999, 1, 24'h000020, 16'h9999};
    run_txn(v, "after reset");

    // Round robin: reset pointer, all three held, winner re-raises after ack.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mdl_dout[i] = 16'h0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, rr_req_addr[i]);
    for (int k = 0; k < 6; k++) begin
      wait_sreq(cyc);
      check($sformatf("rr%0d wait", k), {31'h0, sdram_req}, 32'h1);
      check($sformatf("rr%0d addr", k), {8'h0, sdram_addr}, {8'h0, rr_addr[order[k]]});
      sdram_data = 16'(16'h1100 * (k + 1));
      sdram_ack  = 1'b1;
      @(negedge clk);
      sdram_ack  = 1'b0;
      check($sformatf("rr%0d acks", k), {29'h0, gfx_ack, z80_ack, m68k_ack},
            32'(3'b001 << order[k]));
      set_req(order[k], 1'b0, rr_req_addr[order[k]]);
      @(negedge clk);
      set_req(order[k], 1'b1, rr_req_addr[order[k]]);
    end
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, rr_req_addr[i]);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter Z80_BASE, default 24'h040000, meaning the SDRAM byte offset of the Z80 program ROM.
REQ-002 The block SHALL have parameter GFX_BASE, default 24'h050000, meaning the SDRAM byte offset of the sprite ROM.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port m68k_req, input, 1 bit: 68k ROM fetch request (level).
REQ-006 The block SHALL have port m68k_addr, input, 18 bits: 68k byte address; bit 0 is ignored.
REQ-007 The block SHALL have port m68k_ack, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have port m68k_dout, output, 16 bits: fetched word.
REQ-009 The block SHALL have port z80_req, input, 1 bit: Z80 ROM fetch request (level).
REQ-010 The block SHALL have port z80_addr, input, 16 bits: Z80 byte address.
REQ-011 The block SHALL have port z80_ack, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port z80_dout, output, 8 bits: fetched byte.
REQ-013 The block SHALL have port gfx_req, input, 1 bit: sprite ROM fetch request (level).
REQ-014 The block SHALL have port gfx_addr, input, 20 bits: sprite ROM byte address; bit 0 is ignored.
REQ-015 The block SHALL have port gfx_ack, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port gfx_dout, output, 16 bits: fetched word.
REQ-017 The block SHALL have port sdram_req, output, 1 bit: read request, held until acknowledged.
REQ-018 The block SHALL have port sdram_addr, output, 24 bits: SDRAM byte address; bit 0 is always 0.
REQ-019 The block SHALL have port sdram_ack, input, 1 bit: one-cycle pulse; sdram_data is valid in the same cycle.
REQ-020 The block SHALL have port sdram_data, input, 16 bits: read data.

Function
REQ-021 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-022 In IDLE, when at least one req is high, the block SHALL register the winner and its translated address, set sdram_req=1 and sdram_addr, and enter BUSY at the next edge.
REQ-023 Arbitration SHALL be round-robin over the order m68k, z80, gfx, starting from the requester after the last granted one; a lone requester SHALL always win.
REQ-024 The address translation SHALL be:
  - m68k: {6'b0, m68k_addr[17:1], 1'b0}
  - z80: Z80_BASE + {z80_addr[15:1], 1'b0}
  - gfx: GFX_BASE + {gfx_addr[19:1], 1'b0}
  - all sums are 24-bit, with wrap-around modulo 2^24.
REQ-025 sdram_addr SHALL remain stable throughout BUSY, and sdram_req SHALL stay at 1 until sdram_ack is sampled.
REQ-026 In BUSY, when sdram_ack=1, the block SHALL:
  - clear sdram_req;
  - capture sdram_data into the granted requester's dout;
  - enter DONE.
REQ-027 Data capture SHALL follow these rules:
  - z80_dout = z80_addr[0] ? data[15:8] : data[7:0], using the address captured at grant;
  - the douts of the other requesters SHALL be unchanged.
REQ-028 In DONE, the block SHALL assert the granted requester's ack for exactly one cycle and then return to IDLE; acks are mutually exclusive.
REQ-029 The minimum latency SHALL be: req high at edge N -> sdram_req at N+1 -> sdram_ack at edge M -> ack high in cycle M+1.
REQ-030 A requester SHALL drop req in the cycle after its ack; a req still high in IDLE is a new request.
REQ-031 If the granted req falls during BUSY (abort), the transaction SHALL still complete on the SDRAM side, and in DONE no ack SHALL be pulsed and dout SHALL NOT be updated.
REQ-032 When req rises in the same cycle that another requester is in DONE, that request SHALL be arbitrated in the following IDLE cycle.
REQ-033 An sdram_ack in IDLE or DONE SHALL be ignored.
REQ-034 A dout SHALL hold its value until that requester's next completed fetch.

Reset
REQ-035 While reset=1, the block SHALL immediately force:
  - state to IDLE;
  - sdram_req=0 and sdram_addr=0;
  - all acks to 0 and all douts to 0;
  - the round-robin pointer to "last=gfx", so that m68k has first priority.
REQ-036 A reset during BUSY SHALL abandon the transaction, and the late sdram_ack that follows SHALL be ignored.

Verification
REQ-037 Scenario: m68k_req with m68k_addr=18'h01235, and sdram_ack 3 cycles after sdram_req with data 16'hBEEF -> sdram_addr=24'h001234, then m68k_dout=16'hBEEF and a single m68k_ack pulse, with z80_ack=gfx_ack=0.
REQ-038 Scenario: z80_req with z80_addr=16'h1001 and data 16'hA55A -> sdram_addr=24'h041000 and z80_dout=8'hA5; then z80_addr=16'h1000 -> z80_dout=8'h5A.
REQ-039 Scenario: all three reqs held continuously, each re-raised after its ack -> grant order m68k, z80, gfx, m68k, with no requester starved.
REQ-040 Scenario: gfx_req with gfx_addr=20'hFFFFE and GFX_BASE=24'hFF0000 -> sdram_addr=24'h0EFFFE (wrap-around).
REQ-041 Scenario: m68k_req dropped during BUSY -> sdram_ack is consumed, no m68k_ack is pulsed, m68k_dout is unchanged, and the next grant proceeds normally.
REQ-042 Scenario: reset pulsed during BUSY, followed by a late sdram_ack -> all outputs are 0, no ack is pulsed, and the next m68k_req is served from IDLE.
